// File: rtl/shutter_burst_seq_if.sv
// Bundle of the shutter burst sequencer's control, parameter and status signals.
// The master side (controller or bench) drives requests and parameters; the sequencer is the slave.
interface shutter_burst_seq_if;
    logic        start;
    logic        abort;
    logic [15:0] n_pulses;
    logic [15:0] n_bursts;
    logic [31:0] gap_cycles;
    logic        shutter_in;
    logic        div_en;
    logic        busy;
    logic        done;
    logic        edge_strb;
    logic [15:0] pulse_cnt;
    logic [15:0] burst_cnt;

    modport master (
        output start, abort, n_pulses, n_bursts, gap_cycles, shutter_in,
        input  div_en, busy, done, edge_strb, pulse_cnt, burst_cnt
    );

    modport slave (
        input  start, abort, n_pulses, n_bursts, gap_cycles, shutter_in,
        output div_en, busy, done, edge_strb, pulse_cnt, burst_cnt
    );
endinterface

// File: rtl/shutter_burst_seq.sv
// Shutter burst sequencer: enables the divider for n_pulses shutter edges per burst,
// repeats n_bursts times with an idle gap between bursts, then strobes done.
module shutter_burst_seq (
    input  logic                  clk,
    input  logic                  rst,
    shutter_burst_seq_if.slave    bus
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        RUN   = 3'd1,
        DRAIN = 3'd2,
        GAP   = 3'd3,
        DONE  = 3'd4
    } state_t;

    state_t      state_q;
    logic        shin_prev_q;
    logic        div_en_q;
    logic        busy_q;
    logic        done_q;
    logic        edge_strb_q;
    logic [15:0] pulse_cnt_q;
    logic [15:0] burst_cnt_q;
    logic [15:0] n_pulses_q;
    logic [15:0] n_bursts_q;
    logic [31:0] gap_lat_q;
    logic [31:0] gap_cnt_q;

    logic        rise_det;
    logic        gap_expired;
    logic [15:0] pulse_cnt_d;
    logic [15:0] burst_cnt_d;

    assign rise_det    = bus.shutter_in & ~shin_prev_q;
    assign pulse_cnt_d = pulse_cnt_q + 16'd1;
    assign burst_cnt_d = burst_cnt_q + 16'd1;
    // A zero gap still spends one cycle in GAP; 33-bit compare keeps the +1 from wrapping.
    assign gap_expired = ({1'b0, gap_cnt_q} + 33'd1) >= {1'b0, gap_lat_q};

    // Sequencer state, latched parameters, counters and all registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            shin_prev_q <= 1'b0;
            div_en_q    <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            edge_strb_q <= 1'b0;
            pulse_cnt_q <= 16'd0;
            burst_cnt_q <= 16'd0;
            n_pulses_q  <= 16'd0;
            n_bursts_q  <= 16'd0;
            gap_lat_q   <= 32'd0;
            gap_cnt_q   <= 32'd0;
        end else begin
            shin_prev_q <= bus.shutter_in;
            edge_strb_q <= 1'b0;
            done_q      <= 1'b0;
            if (bus.abort) begin
                state_q  <= IDLE;
                div_en_q <= 1'b0;
                busy_q   <= 1'b0;
            end else begin
                case (state_q)
                    IDLE: begin
                        if (bus.start) begin
                            if ((bus.n_pulses != 16'd0) && (bus.n_bursts != 16'd0)) begin
                                n_pulses_q  <= bus.n_pulses;
                                n_bursts_q  <= bus.n_bursts;
                                gap_lat_q   <= bus.gap_cycles;
                                pulse_cnt_q <= 16'd0;
                                burst_cnt_q <= 16'd0;
                                state_q     <= RUN;
                                div_en_q    <= 1'b1;
                                busy_q      <= 1'b1;
                            end else begin
                                state_q <= DONE;
                                busy_q  <= 1'b1;
                                done_q  <= 1'b1;
                            end
                        end else begin
                            state_q <= IDLE;
                        end
                    end
                    RUN: begin
                        if (rise_det) begin
                            pulse_cnt_q <= pulse_cnt_d;
                            edge_strb_q <= 1'b1;
                            if (pulse_cnt_d == n_pulses_q) begin
                                div_en_q <= 1'b0;
                                state_q  <= DRAIN;
                            end else begin
                                state_q <= RUN;
                            end
                        end else begin
                            state_q <= RUN;
                        end
                    end
                    // Wait for the last shutter high phase to finish before closing the burst.
                    DRAIN: begin
                        if (!bus.shutter_in) begin
                            burst_cnt_q <= burst_cnt_d;
                            if (burst_cnt_d == n_bursts_q) begin
                                state_q <= DONE;
                                done_q  <= 1'b1;
                            end else begin
                                state_q     <= GAP;
                                gap_cnt_q   <= 32'd0;
                                pulse_cnt_q <= 16'd0;
                            end
                        end else begin
                            state_q <= DRAIN;
                        end
                    end
                    GAP: begin
                        if (gap_expired) begin
                            state_q  <= RUN;
                            div_en_q <= 1'b1;
                        end else begin
                            gap_cnt_q <= gap_cnt_q + 32'd1;
                        end
                    end
                    DONE: begin
                        state_q <= IDLE;
                        busy_q  <= 1'b0;
                    end
                    default: begin
                        state_q  <= IDLE;
                        div_en_q <= 1'b0;
                        busy_q   <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign bus.div_en    = div_en_q;
    assign bus.busy      = busy_q;
    assign bus.done      = done_q;
    assign bus.edge_strb = edge_strb_q;
    assign bus.pulse_cnt = pulse_cnt_q;
    assign bus.burst_cnt = burst_cnt_q;

endmodule

// File: doc/shutter_burst_seq.md
SHUTTER_BURST_SEQ -- requirements
Module: shutter_burst_seq

Interface
REQ-001 The block SHALL have ports: clk  input  1  system clock (100 MHz), all logic on rising edge.
REQ-002 The block SHALL have ports: rst  input  1  reset, asynchronous, active-high.
REQ-003 The block SHALL have ports: start  input  1  one-cycle request to begin a burst sequence.
REQ-004 The block SHALL have ports: abort  input  1  level; terminates any sequence.
REQ-005 The block SHALL have ports: n_pulses  input  16  shutter pulses per burst.
REQ-006 The block SHALL have ports: n_bursts  input  16  bursts per sequence.
REQ-007 The block SHALL have ports: gap_cycles  input  32  clk cycles idle between bursts.
REQ-008 The block SHALL have ports: shutter_in  input  1  divided shutter clock from the divider stage, synchronous to clk.
REQ-009 The block SHALL have ports: div_en  output  1  enable to the divider stage.
REQ-010 The block SHALL have ports: busy  output  1  high in any state other than IDLE.
REQ-011 The block SHALL have ports: done  output  1  one-cycle completion strobe.
REQ-012 The block SHALL have ports: edge_strb  output  1  one-cycle strobe per counted shutter rising edge.
REQ-013 The block SHALL have ports: pulse_cnt  output  16  edges counted in current burst.
REQ-014 The block SHALL have ports: burst_cnt  output  16  bursts completed in current sequence.

Function
REQ-015 States SHALL be IDLE, RUN, DRAIN, GAP, DONE; all outputs registered.
REQ-016 Rising edge detect SHALL be shutter_in=1 with previous-cycle shutter_in=0; previous-value register samples every cycle.
REQ-017 IDLE: start with n_pulses!=0 and n_bursts!=0 SHALL latch n_pulses, n_bursts, gap_cycles, clear pulse_cnt and burst_cnt, go RUN, div_en=1 next cycle.
REQ-018 IDLE: start with n_pulses=0 or n_bursts=0 SHALL go DONE without asserting div_en.
REQ-019 Latched parameters SHALL be used for the whole sequence; input changes mid-sequence SHALL be ignored.
REQ-020 start outside IDLE SHALL be ignored.
REQ-021 RUN: each detected rising edge SHALL increment pulse_cnt and pulse edge_strb in the same cycle; edges outside RUN SHALL not be counted.
REQ-022 RUN: the edge that makes pulse_cnt equal n_pulses SHALL clear div_en and move to DRAIN on the next cycle.
REQ-023 DRAIN: when shutter_in=0, burst_cnt SHALL increment; if new burst_cnt equals n_bursts go DONE, else go GAP with gap counter cleared.
REQ-024 GAP: pulse_cnt SHALL clear on entry; after gap_cycles cycles in GAP (gap_cycles=0: one cycle) SHALL go RUN with div_en=1.
REQ-025 DONE: done SHALL be 1 for exactly one cycle, then IDLE; pulse_cnt and burst_cnt hold final values until the next accepted start.
REQ-026 abort SHALL take priority over all transitions: next cycle state=IDLE, div_en=0, no done strobe, counters hold.
REQ-027 Simultaneous start and abort in IDLE SHALL leave the block in IDLE.
REQ-028 Counters SHALL never wrap; pulse_cnt saturates at n_pulses by construction, gap counter 32-bit.

Reset
REQ-029 rst SHALL asynchronously force state=IDLE, div_en=0, busy=0, done=0, edge_strb=0, pulse_cnt=0, burst_cnt=0, gap counter=0, edge-detect register=0.
REQ-030 rst asserted mid-sequence SHALL drop div_en immediately; no done strobe SHALL follow deassertion.

Verification
REQ-031 n_pulses=3, n_bursts=1, divider t_high=t_low=2, start -> exactly 3 edge_strb, div_en low after 3rd edge, done once, burst_cnt=1.
REQ-032 n_pulses=2, n_bursts=3, gap_cycles=10 -> 6 edge_strb total, div_en low >=10 cycles between bursts, done once, burst_cnt=3.
REQ-033 n_pulses=0, start -> done one cycle later-path, div_en never asserted, busy high only during DONE.
REQ-034 abort asserted after 2nd edge of n_pulses=5 -> IDLE next cycle, div_en=0, no done, pulse_cnt=2.
REQ-035 start pulsed again during RUN and n_pulses changed mid-run -> no restart, original count honoured.
REQ-036 rst asserted in GAP -> all outputs zero immediately; fresh start afterwards runs full sequence.
